alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational ALU between two requesters. It sits between two client pipelines and a single ALU instance, which is instantiated alongside it and wired to its `alu_*` ports. The block accepts one operation at a time over a valid/ready handshake and registers the operands into the ALU. It then captures the ALU result and Z flag, and returns them on a shared response channel tagged with the requester id.

---
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Handshake cycle T -> rsp_valid from edge T+2; requests stall (ready low) until the response is taken.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [4:0]   req0_fn,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [4:0]   req1_fn,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_fn,
  input  logic [N-1:0] alu_r,
  input  logic         alu_fz,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_r,
  output logic         rsp_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_id;
  logic   any_valid;
  logic   handshake;

  always_comb begin
    any_valid  = req0_valid | req1_valid;
    // On a tie the requester that did not win last time goes next.
    grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && reset_n && any_valid) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
    handshake = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fn     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_r      <= '0;
      rsp_z      <= 1'b0;
    end else begin
      if (state == IDLE && handshake) begin
        alu_a      <= grant_id ? req1_a  : req0_a;
        alu_b      <= grant_id ? req1_b  : req0_b;
        alu_fn     <= grant_id ? req1_fn : req0_fn;
        rsp_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_r     <= alu_r;
        rsp_z     <= alu_fz;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* ports.
module tb_alu_arbiter;
  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_fn, req1_fn;
  logic [N-1:0] alu_a, alu_b, alu_r;
  logic [4:0]   alu_fn;
  logic         alu_fz;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_z;
  logic [N-1:0] rsp_r;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_arbiter #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_r(alu_r), .alu_fz(alu_fz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_z(rsp_z)
  );

  // fn = {subtract, bool1, bool0, shft, math}
  always_comb begin
    if (alu_fn[0])      alu_r = alu_fn[4] ? alu_a - alu_b : alu_a + alu_b;
    else if (alu_fn[1]) alu_r = alu_a << alu_b[4:0];
    else begin
      case (alu_fn[3:2])
        2'd0:    alu_r = alu_a & alu_b;
        2'd1:    alu_r = alu_a | alu_b;
        2'd2:    alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
    end
    alu_fz = (alu_r == '0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_fn = '0;
    req1_a = '0; req1_b = '0; req1_fn = '0;
    rsp_ready = 1'b0;
    @(negedge clock); #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_r} !== {3'b000, 32'd0}) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%b z=%b r=%0d expected all 0", rsp_valid, rsp_id, rsp_z, rsp_r);
    end
    checks++;
    if ({alu_a, alu_b, alu_fn} !== '0) begin
      errors++; $display("FAIL reset_alu: got a=%0d b=%0d fn=%b expected 0", alu_a, alu_b, alu_fn);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_fn = 5'b00001; rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL add_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clock);
    req0_valid = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_fn, rsp_valid} !== {32'd5, 32'd3, 5'b00001, 1'b0}) begin
      errors++; $display("FAIL add_exec: got a=%0d b=%0d fn=%b v=%b expected 5 3 00001 0", alu_a, alu_b, alu_fn, rsp_valid);
    end
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_r} !== {3'b100, 32'd8}) begin
      errors++; $display("FAIL add_rsp: got v=%b id=%b z=%b r=%0d expected 1 0 0 8", rsp_valid, rsp_id, rsp_z, rsp_r);
    end
    @(negedge clock);
    req0_valid = 1'b1; #1;
    checks++;
    if ({rsp_valid, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL add_idle: got v=%b rdy0=%b expected 0 1", rsp_valid, req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_sub();
    @(negedge clock);
    req1_valid = 1'b1; req1_a = 7; req1_b = 7; req1_fn = 5'b10001; rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL sub_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    @(negedge clock);
    req1_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_r} !== {3'b111, 32'd0}) begin
      errors++; $display("FAIL sub_rsp: got v=%b id=%b z=%b r=%0d expected 1 1 1 0", rsp_valid, rsp_id, rsp_z, rsp_r);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[4];
    int rsp_ids[4];
    int rsp_rs[4];
    int n_acc = 0;
    int n_rsp = 0;
    req0_a = 1; req0_b = 1; req0_fn = 5'b00001;
    req1_a = 2; req1_b = 2; req1_fn = 5'b00001;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (n_acc < 4) acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (rsp_valid) begin
        if (n_rsp < 4) begin
          rsp_ids[n_rsp] = int'(rsp_id);
          rsp_rs[n_rsp]  = int'(rsp_r);
        end
        n_rsp++;
      end
      @(negedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n_acc !== 4 || n_rsp !== 4) begin
      errors++; $display("FAIL b2b_count: got acc=%0d rsp=%0d expected 4 4", n_acc, n_rsp);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rsp_ids[i] !== (i % 2) || rsp_rs[i] !== ((i % 2) ? 4 : 2)) begin
          errors++; $display("FAIL b2b_rsp%0d: got id=%0d r=%0d expected id=%0d r=%0d", i, rsp_ids[i], rsp_rs[i], i % 2, (i % 2) ? 4 : 2);
        end
        checks++;
        if (acc_cyc[i] !== 3 * i) begin
          errors++; $display("FAIL b2b_acc%0d: got cycle %0d expected %0d", i, acc_cyc[i], 3 * i);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_hold();
    req0_valid = 1'b1; req0_a = 9; req0_b = 6; req0_fn = 5'b10001; rsp_ready = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL hold_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clock);
    req0_valid = 1'b0;
    @(negedge clock);
    req1_valid = 1'b1; req1_a = 4; req1_b = 4; req1_fn = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_z, rsp_r, req0_ready, req1_ready} !== {3'b100, 32'd3, 2'b00}) begin
        errors++; $display("FAIL hold_stable%0d: got v=%b id=%b z=%b r=%0d rdy=%b%b expected 1 0 0 3 00", k, rsp_valid, rsp_id, rsp_z, rsp_r, req0_ready, req1_ready);
      end
      @(negedge clock);
    end
    rsp_ready = 1'b1; #1;
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL hold_release: got v=%b rdy1=%b expected 1 0", rsp_valid, req1_ready);
    end
    @(negedge clock); #1;
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_accept: got v=%b rdy1=%b expected 0 1", rsp_valid, req1_ready);
    end
    @(negedge clock);
    req1_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_r} !== {3'b110, 32'd8}) begin
      errors++; $display("FAIL hold_rsp1: got v=%b id=%b z=%b r=%0d expected 1 1 0 8", rsp_valid, rsp_id, rsp_z, rsp_r);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_exec();
    req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_fn = 5'b00001; rsp_ready = 1'b1;
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 3; req1_b = 3; req1_fn = 5'b00001;
    reset_n = 1'b0; #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000 || alu_a !== 32'd0) begin
      errors++; $display("FAIL rstx_drop: got v=%b rdy=%b%b a=%0d expected 0 00 0", rsp_valid, req0_ready, req1_ready, alu_a);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstx_norsp: got v=%b expected 0", rsp_valid);
    end
    req0_valid = 1'b1; req0_a = 6; req0_b = 1; req0_fn = 5'b00001;
    reset_n = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rstx_tie: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clock);
    req0_valid = 1'b0; #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      errors++; $display("FAIL rstx_exec: got v=%b rdy=%b%b expected 0 00", rsp_valid, req0_ready, req1_ready);
    end
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_id, rsp_r} !== {2'b10, 32'd7}) begin
      errors++; $display("FAIL rstx_rsp0: got v=%b id=%b r=%0d expected 1 0 7", rsp_valid, rsp_id, rsp_r);
    end
    @(negedge clock); #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL rstx_next: got rdy1=%b expected 1", req1_ready);
    end
    @(negedge clock);
    req1_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_id, rsp_r} !== {2'b11, 32'd6}) begin
      errors++; $display("FAIL rstx_rsp1: got v=%b id=%b r=%0d expected 1 1 6", rsp_valid, rsp_id, rsp_r);
    end
    @(negedge clock);
  endtask

  task automatic test_deassert();
    int n_rsp = 0;
    int n_grant = 0;
    logic [N-1:0] seen_r = '0;
    req0_valid = 1'b1; req0_a = 10; req0_b = 5; req0_fn = 5'b00001; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL deas_grant: got rdy0=%b expected 1", req0_ready);
    end
    @(negedge clock);
    req0_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid) begin n_rsp++; seen_r = rsp_r; end
      if (req0_ready || req1_ready) n_grant++;
      @(negedge clock);
    end
    checks++;
    if (n_rsp !== 1 || n_grant !== 0 || seen_r !== 32'd15) begin
      errors++; $display("FAIL deas_single: got rsp=%0d grants=%0d r=%0d expected 1 0 15", n_rsp, n_grant, seen_r);
    end
    req1_valid = 1'b1; req1_a = 1; req1_b = 1; req1_fn = 5'b00001;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL deas_offer: got rdy1=%b expected 1", req1_ready);
    end
    #2 req1_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (alu_a !== 32'd10) begin
      errors++; $display("FAIL deas_nohs: got a=%0d expected 10", alu_a);
    end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL deas_lastgrant: got %b expected 01", {req0_ready, req1_ready});
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_hold();
    test_reset_exec();
    test_deassert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
